ps2_host_cmd: RTL and testbench

Host-side command sequencer for the keyboard PS/2 link. It sits above `ps2_bus` and drives its `enable` / `tx_data` handshake. It accepts one high-level command at a time (reset, set LEDs, set typematic, echo), sends the opcode byte and any argument byte, and checks each device response. FE resends and silent devices are retried, and the outcome is reported on a done/error pulse. Bytes the device sends outside a command exchange are forwarded to the scan-code consumer.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_timeout_timer.sv | 26 ++
 rtl/ps2_host_cmd.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_cmd.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 host command sequencer:
// command/response bytes, the cmd_op encoding and the sequencer state set.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_LEDS      = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ECHO      = 8'hEE;

    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;
    localparam logic [7:0] RSP_ECHO      = 8'hEE;

    typedef enum logic [1:0] {
        OP_RESET     = 2'd0,
        OP_LEDS      = 2'd1,
        OP_TYPEMATIC = 2'd2,
        OP_ECHO      = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_START,
        ST_TX_BUSY,
        ST_RSP_WAIT,
        ST_BAT_WAIT,
        ST_DONE_OK,
        ST_DONE_ERR
    } state_t;

    function automatic logic [7:0] opcode_byte(input cmd_op_t op);
        case (op)
            OP_RESET:     return CMD_RESET;
            OP_LEDS:      return CMD_LEDS;
            OP_TYPEMATIC: return CMD_TYPEMATIC;
            default:      return CMD_ECHO;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating cycle counter with synchronous clear and count enable; expired
// flags that the count has reached limit-1, i.e. limit enabled cycles elapsed.
module ps2_timeout_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock_quarter,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock_quarter) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = (count >= (limit - WIDTH'(1)));

endmodule

// File: rtl/ps2_host_cmd.sv
// Host-side PS/2 command sequencer: sends opcode/argument bytes through
// ps2_bus, checks device responses, retries, and forwards unsolicited bytes.
module ps2_host_cmd
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 20000,
    parameter int unsigned BAT_TIMEOUT = 2000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clock_quarter,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       done,
    output logic       error,
    output logic [7:0] resp,
    output logic       scan_valid,
    output logic [7:0] scan_data,
    output logic       bus_enable,
    output logic [7:0] bus_tx_data,
    input  logic       bus_tx_ready,
    input  logic       bus_tx_faild,
    input  logic       bus_rx_complete,
    input  logic [7:0] bus_rx_data
);

    localparam int unsigned TW = $clog2(BAT_TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t          state, next;
    cmd_op_t         op_q;
    logic [7:0]      arg_q;
    logic            byte_idx;
    logic [RW-1:0]   retry_cnt;
    logic            rx_seen;
    logic            live;
    logic [7:0]      resp_q;
    logic            scan_valid_q;
    logic [7:0]      scan_data_q;

    logic            latch_cmd;
    logic            advance;
    logic            do_retry;
    logic            inc_retry;
    logic            forward;
    logic            resp_load;
    logic [7:0]      resp_val;
    logic [7:0]      cur_byte;

    logic            timer_clear;
    logic            timer_en;
    logic [TW-1:0]   timer_limit;
    logic            timer_expired;

    assign cur_byte = byte_idx ? arg_q : opcode_byte(op_q);

    always_comb begin
        next      = state;
        latch_cmd = 1'b0;
        advance   = 1'b0;
        do_retry  = 1'b0;
        inc_retry = 1'b0;
        forward   = 1'b0;
        resp_load = 1'b0;
        resp_val  = '0;
        case (state)
            ST_IDLE: begin
                forward = bus_rx_complete;
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    next      = ST_TX_START;
                end
            end
            ST_TX_START: begin
                forward = bus_rx_complete;
                if (bus_tx_ready) next = ST_TX_BUSY;
            end
            ST_TX_BUSY: begin
                forward = bus_rx_complete;
                // A byte received here means the bus served a device read
                // instead of our transmit: resend without charging a retry.
                if (bus_tx_ready) begin
                    if (rx_seen || bus_rx_complete) next = ST_TX_START;
                    else if (bus_tx_faild)          do_retry = 1'b1;
                    else                            next = ST_RSP_WAIT;
                end
            end
            ST_RSP_WAIT: begin
                if (bus_rx_complete) begin
                    if (bus_rx_data == RSP_ACK) begin
                        if (!byte_idx && (op_q == OP_LEDS || op_q == OP_TYPEMATIC)) begin
                            advance = 1'b1;
                            next    = ST_TX_START;
                        end else if (op_q == OP_RESET) begin
                            next = ST_BAT_WAIT;
                        end else begin
                            resp_load = 1'b1;
                            resp_val  = RSP_ACK;
                            next      = ST_DONE_OK;
                        end
                    end else if (bus_rx_data == RSP_ECHO && op_q == OP_ECHO) begin
                        resp_load = 1'b1;
                        resp_val  = RSP_ECHO;
                        next      = ST_DONE_OK;
                    end else if (bus_rx_data == RSP_RESEND) begin
                        do_retry = 1'b1;
                    end else begin
                        forward = 1'b1;
                    end
                end else if (timer_expired) begin
                    do_retry = 1'b1;
                end
            end
            ST_BAT_WAIT: begin
                if (bus_rx_complete) begin
                    if (bus_rx_data == RSP_BAT_OK) begin
                        resp_load = 1'b1;
                        resp_val  = RSP_BAT_OK;
                        next      = ST_DONE_OK;
                    end else if (bus_rx_data == RSP_BAT_FAIL) begin
                        resp_load = 1'b1;
                        resp_val  = RSP_BAT_FAIL;
                        next      = ST_DONE_ERR;
                    end else begin
                        forward = 1'b1;
                    end
                end else if (timer_expired) begin
                    next = ST_DONE_ERR;
                end
            end
            ST_DONE_OK, ST_DONE_ERR: begin
                forward = bus_rx_complete;
                next    = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase

        if (do_retry) begin
            if (retry_cnt == RW'(MAX_RETRY)) begin
                next = ST_DONE_ERR;
            end else begin
                inc_retry = 1'b1;
                next      = ST_TX_START;
            end
        end
    end

    always_ff @(posedge clock_quarter) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= OP_RESET;
            arg_q        <= '0;
            byte_idx     <= 1'b0;
            retry_cnt    <= '0;
            rx_seen      <= 1'b0;
            live         <= 1'b0;
            resp_q       <= '0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
        end else begin
            state        <= next;
            live         <= 1'b1;
            scan_valid_q <= forward;
            if (forward) scan_data_q <= bus_rx_data;
            if (latch_cmd) begin
                op_q      <= cmd_op_t'(cmd_op);
                arg_q     <= cmd_arg;
                byte_idx  <= 1'b0;
                retry_cnt <= '0;
                resp_q    <= '0;
            end
            if (advance) begin
                byte_idx  <= 1'b1;
                retry_cnt <= '0;
            end
            if (inc_retry) retry_cnt <= retry_cnt + RW'(1);
            if (resp_load) resp_q <= resp_val;
            rx_seen <= (state == ST_TX_BUSY && next == ST_TX_BUSY) ? (rx_seen | bus_rx_complete) : 1'b0;
        end
    end

    // The count restarts on every state change so each wait phase is timed alone.
    assign timer_en    = (state == ST_RSP_WAIT) || (state == ST_BAT_WAIT);
    assign timer_clear = !timer_en || (next != state);
    assign timer_limit = (state == ST_BAT_WAIT) ? TW'(BAT_TIMEOUT) : TW'(ACK_TIMEOUT);

    ps2_timeout_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clock_quarter(clock_quarter),
        .reset        (reset),
        .clear        (timer_clear),
        .enable       (timer_en),
        .limit        (timer_limit),
        .expired      (timer_expired)
    );

    assign cmd_ready   = (state == ST_IDLE) && live;
    assign bus_enable  = (state == ST_TX_START) && bus_tx_ready;
    assign bus_tx_data = (state == ST_TX_START || state == ST_TX_BUSY) ? cur_byte : '0;
    assign done        = (state == ST_DONE_OK);
    assign error       = (state == ST_DONE_ERR);
    assign resp        = resp_q;
    assign scan_valid  = scan_valid_q;
    assign scan_data   = scan_data_q;

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Directed bench for ps2_host_cmd: scripted bus/device behaviour with
// hand-computed expected bytes, pulses and latencies.
module tb_ps2_host_cmd;

    logic       clock_quarter = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_arg = '0;
    logic       done, error;
    logic [7:0] resp;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       bus_enable;
    logic [7:0] bus_tx_data;
    logic       bus_tx_ready = 1'b1;
    logic       bus_tx_faild = 1'b0;
    logic       bus_rx_complete = 1'b0;
    logic [7:0] bus_rx_data = '0;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_err = 0, n_sent = 0;

    ps2_host_cmd #(
        .ACK_TIMEOUT(100),
        .BAT_TIMEOUT(300),
        .MAX_RETRY  (3)
    ) dut (
        .clock_quarter  (clock_quarter),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .done           (done),
        .error          (error),
        .resp           (resp),
        .scan_valid     (scan_valid),
        .scan_data      (scan_data),
        .bus_enable     (bus_enable),
        .bus_tx_data    (bus_tx_data),
        .bus_tx_ready   (bus_tx_ready),
        .bus_tx_faild   (bus_tx_faild),
        .bus_rx_complete(bus_rx_complete),
        .bus_rx_data    (bus_rx_data)
    );

    always #5 clock_quarter = ~clock_quarter;

    always @(posedge clock_quarter) begin
        if (done)       n_done <= n_done + 1;
        if (error)      n_err  <= n_err + 1;
        if (bus_enable) n_sent <= n_sent + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        check_eq("cmd_ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clock_quarter);
        cmd_valid = 1'b0;
    endtask

    // Waits for bus_enable, checks the byte, then plays a successful bus transmit.
    task automatic expect_tx(input string tag, input logic [7:0] exp, input int max_wait, output int waited);
        waited = 0;
        while (!bus_enable && waited < max_wait) begin
            @(negedge clock_quarter);
            waited++;
        end
        check_eq({tag, "_enable"}, bus_enable, 1);
        check_eq({tag, "_data"}, bus_tx_data, exp);
        @(posedge clock_quarter);
        #1 bus_tx_ready = 1'b0;
        @(negedge clock_quarter);
        check_eq({tag, "_enable_one_cycle"}, bus_enable, 0);
        repeat (2) @(negedge clock_quarter);
        bus_tx_ready = 1'b1;
        @(negedge clock_quarter);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus_rx_complete = 1'b1;
        bus_rx_data     = b;
        @(negedge clock_quarter);
        bus_rx_complete = 1'b0;
    endtask

    task automatic wait_result(input int max_wait, output int waited);
        waited = 0;
        while (!done && !error && waited < max_wait) begin
            @(negedge clock_quarter);
            waited++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, s0, d0, e0;

        // Reset state
        repeat (3) @(negedge clock_quarter);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_outputs", {done, error, scan_valid, bus_enable}, 0);
        check_eq("rst_bytes", {resp, scan_data, bus_tx_data}, 0);
        reset = 1'b0;
        @(negedge clock_quarter);
        check_eq("rst_cmd_ready_after", cmd_ready, 1);

        // LED command, with a stray cmd_valid that must be ignored
        s0 = n_sent;
        issue(2'd1, 8'h07);
        expect_tx("led_op", 8'hED, 5, w);
        check_eq("led_accept_latency", w, 0);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        @(negedge clock_quarter);
        cmd_valid = 1'b0;
        rx_byte(8'hFA);
        expect_tx("led_arg", 8'h07, 5, w);
        rx_byte(8'hFA);
        wait_result(10, w);
        check_eq("led_done", done, 1);
        check_eq("led_done_latency", w, 0);
        check_eq("led_error", error, 0);
        check_eq("led_resp", resp, 8'hFA);
        @(negedge clock_quarter);
        check_eq("led_done_pulse", done, 0);
        check_eq("led_cmd_ready", cmd_ready, 1);
        check_eq("led_sent", n_sent - s0, 2);

        // Resend: FE twice on the opcode, stray byte forwarded during arg wait
        s0 = n_sent;
        e0 = n_err;
        issue(2'd2, 8'h20);
        for (int i = 0; i < 2; i++) begin
            expect_tx("typ_op_resend", 8'hF3, 5, w);
            rx_byte(8'hFE);
        end
        expect_tx("typ_op", 8'hF3, 5, w);
        rx_byte(8'hFA);
        expect_tx("typ_arg", 8'h20, 5, w);
        rx_byte(8'h12);
        check_eq("typ_scan_valid", scan_valid, 1);
        check_eq("typ_scan_data", scan_data, 8'h12);
        rx_byte(8'hFA);
        wait_result(10, w);
        check_eq("typ_done", done, 1);
        check_eq("typ_resp", resp, 8'hFA);
        @(negedge clock_quarter);
        check_eq("typ_sent", n_sent - s0, 4);
        check_eq("typ_no_error", n_err - e0, 0);

        // Retry exhaustion with a silent device
        s0 = n_sent;
        e0 = n_err;
        d0 = n_done;
        issue(2'd3, 8'h00);
        for (int i = 0; i < 4; i++) expect_tx("echo_silent", 8'hEE, 300, w);
        wait_result(300, w);
        check_eq("exh_error", error, 1);
        check_eq("exh_done", done, 0);
        @(negedge clock_quarter);
        check_eq("exh_err_count", n_err - e0, 1);
        check_eq("exh_done_count", n_done - d0, 0);
        check_eq("exh_sent", n_sent - s0, 4);

        // Reset command: FA then AA
        issue(2'd0, 8'h00);
        expect_tx("rst_cmd_op", 8'hFF, 5, w);
        rx_byte(8'hFA);
        repeat (5) @(negedge clock_quarter);
        rx_byte(8'hAA);
        wait_result(10, w);
        check_eq("bat_ok_done", done, 1);
        check_eq("bat_ok_resp", resp, 8'hAA);
        @(negedge clock_quarter);

        // Reset command: FA then FC
        issue(2'd0, 8'h00);
        expect_tx("rst_cmd_op2", 8'hFF, 5, w);
        rx_byte(8'hFA);
        repeat (5) @(negedge clock_quarter);
        rx_byte(8'hFC);
        wait_result(10, w);
        check_eq("bat_fail_error", error, 1);
        check_eq("bat_fail_done", done, 0);
        check_eq("bat_fail_resp", resp, 8'hFC);
        @(negedge clock_quarter);

        // Read preemption: retry budget must stay intact (3 timeouts then success)
        s0 = n_sent;
        issue(2'd3, 8'h00);
        check_eq("pre_enable", bus_enable, 1);
        @(posedge clock_quarter);
        #1 bus_tx_ready = 1'b0;
        @(negedge clock_quarter);
        rx_byte(8'h1C);
        check_eq("pre_scan_valid", scan_valid, 1);
        check_eq("pre_scan_data", scan_data, 8'h1C);
        bus_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_tx("pre_resend", 8'hEE, 300, w);
            if (i == 3) rx_byte(8'hEE);
        end
        wait_result(10, w);
        check_eq("pre_done", done, 1);
        check_eq("pre_resp", resp, 8'hEE);
        @(negedge clock_quarter);
        check_eq("pre_sent", n_sent - s0, 5);

        // Idle forwarding
        rx_byte(8'h5A);
        check_eq("idle_scan_valid", scan_valid, 1);
        check_eq("idle_scan_data", scan_data, 8'h5A);
        @(negedge clock_quarter);
        check_eq("idle_scan_pulse", scan_valid, 0);

        // Reset mid-command during RSP_WAIT
        d0 = n_done;
        e0 = n_err;
        issue(2'd1, 8'h02);
        expect_tx("mid_op", 8'hED, 5, w);
        reset = 1'b1;
        @(negedge clock_quarter);
        check_eq("mid_cmd_ready", cmd_ready, 0);
        check_eq("mid_outputs", {done, error, scan_valid, bus_enable}, 0);
        check_eq("mid_bytes", {resp, scan_data, bus_tx_data}, 0);
        reset = 1'b0;
        @(negedge clock_quarter);
        check_eq("mid_cmd_ready_after", cmd_ready, 1);
        repeat (150) @(negedge clock_quarter);
        check_eq("mid_no_done", n_done - d0, 0);
        check_eq("mid_no_error", n_err - e0, 0);
        check_eq("mid_idle_enable", bus_enable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
